// File: rtl/player_bullet.sv
// Player-shot engine: pooled upward bullets with fire cooldown and enemy hit detection.
// Optional SCORE_EN adds a saturating 16-bit hit score output.
module player_bullet #(
    parameter int unsigned NSLOT    = 4,
    parameter int unsigned SPEED    = 8,
    parameter int unsigned COOLDOWN = 6,
    parameter int unsigned HIT_R    = 12,
    parameter int unsigned TOP      = 8
) (
    input  logic                  clk22,
    input  logic                  rst,
    input  logic                  fire,
    input  logic [9:0]            reimux,
    input  logic [9:0]            reimuy,
    input  logic [9:0]            enmx1,
    input  logic [9:0]            enmx2,
    input  logic [9:0]            enmx3,
    input  logic [9:0]            enmx4,
    input  logic [9:0]            enmy1,
    input  logic [9:0]            enmy2,
    input  logic [9:0]            enmy3,
    input  logic [9:0]            enmy4,
    input  logic                  enm1,
    input  logic                  enm2,
    input  logic                  enm3,
    input  logic                  enm4,
    output logic [NSLOT-1:0]      bullet,
    output logic [10*NSLOT-1:0]   bulletx,
    output logic [10*NSLOT-1:0]   bullety,
    output logic [3:0]            enm_hit
`ifdef SCORE_EN
    ,
    output logic [15:0]           score
`endif
);

    localparam int unsigned NENM = 4;
    localparam int unsigned CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [CD_W-1:0] CD_LOAD   = CD_W'(COOLDOWN - 1);
    localparam logic [10:0]     HIT_R11   = 11'(HIT_R);
    localparam logic [10:0]     EXIT_Y    = 11'(TOP + SPEED);
    localparam logic [9:0]      SPEED10   = 10'(SPEED);
    localparam logic [9:0]      SPAWN_OFS = 10'd12;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FLY  = 1'b1
    } slot_state_e;

    slot_state_e     r_state [NSLOT];
    logic [9:0]      r_x     [NSLOT];
    logic [9:0]      r_y     [NSLOT];
    logic [3:0]      r_hit;
    logic [CD_W-1:0] r_cd;

    slot_state_e     w_state_nxt [NSLOT];
    logic [9:0]      w_x_nxt     [NSLOT];
    logic [9:0]      w_y_nxt     [NSLOT];
    logic [3:0]      w_hit_nxt;
    logic [CD_W-1:0] w_cd_nxt;
    logic            w_found;
    logic            w_idle_seen;
    logic [9:0]      w_spawn_y;

    logic [9:0] w_ex [NENM];
    logic [9:0] w_ey [NENM];
    logic [3:0] w_alive;

    assign w_ex    = '{enmx1, enmx2, enmx3, enmx4};
    assign w_ey    = '{enmy1, enmy2, enmy3, enmy4};
    assign w_alive = {enm4, enm3, enm2, enm1};

    assign w_spawn_y = (reimuy < SPAWN_OFS) ? 10'd0 : reimuy - SPAWN_OFS;

    // Square overlap test in 11 bits so x/y near 1023 cannot wrap.
    function automatic logic f_collide(input logic [9:0] bx, input logic [9:0] by,
                                       input logic [9:0] ex, input logic [9:0] ey);
        logic [10:0] bx1, by1, ex1, ey1;
        bx1 = {1'b0, bx};
        by1 = {1'b0, by};
        ex1 = {1'b0, ex};
        ey1 = {1'b0, ey};
        return (bx1 + HIT_R11 > ex1) && (bx1 < ex1 + HIT_R11) &&
               (by1 + HIT_R11 > ey1) && (by1 < ey1 + HIT_R11);
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_hit_nxt   = 4'd0;
        w_cd_nxt    = (r_cd != '0) ? r_cd - CD_W'(1) : r_cd;
        w_found     = 1'b0;
        w_idle_seen = 1'b0;

        // Flying slots: hit beats exit beats move.
        for (int i = 0; i < int'(NSLOT); i++) begin
            if (r_state[i] == S_FLY) begin
                w_found = 1'b0;
                for (int k = 0; k < int'(NENM); k++) begin
                    if (!w_found && w_alive[k] && f_collide(r_x[i], r_y[i], w_ex[k], w_ey[k])) begin
                        w_found      = 1'b1;
                        w_hit_nxt[k] = 1'b1;
                    end
                end
                if (w_found) begin
                    w_state_nxt[i] = S_IDLE;
                end else if ({1'b0, r_y[i]} < EXIT_Y) begin
                    w_state_nxt[i] = S_IDLE;
                end else begin
                    w_y_nxt[i] = r_y[i] - SPEED10;
                end
            end
        end

        // Spawn into the lowest slot idle at the start of this tick.
        for (int i = 0; i < int'(NSLOT); i++) begin
            if (!w_idle_seen && r_state[i] == S_IDLE) begin
                w_idle_seen = 1'b1;
                if (fire && r_cd == '0) begin
                    w_state_nxt[i] = S_FLY;
                    w_x_nxt[i]     = reimux;
                    w_y_nxt[i]     = w_spawn_y;
                    w_cd_nxt       = CD_LOAD;
                end
            end
        end
    end

    always_ff @(posedge clk22) begin
        if (rst) begin
            for (int i = 0; i < int'(NSLOT); i++) begin
                r_state[i] <= S_IDLE;
                r_x[i]     <= 10'd0;
                r_y[i]     <= 10'd0;
            end
            r_hit <= 4'd0;
            r_cd  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_hit   <= w_hit_nxt;
            r_cd    <= w_cd_nxt;
        end
    end

    for (genvar g = 0; g < int'(NSLOT); g++) begin : g_slot_out
        assign bullet[g]           = (r_state[g] == S_FLY);
        assign bulletx[10*g +: 10] = r_x[g];
        assign bullety[10*g +: 10] = r_y[g];
    end

    assign enm_hit = r_hit;

`ifdef SCORE_EN
    logic [15:0] r_score;
    logic [2:0]  w_pop;
    logic [16:0] w_score_sum;

    assign w_pop       = 3'(w_hit_nxt[0]) + 3'(w_hit_nxt[1]) + 3'(w_hit_nxt[2]) + 3'(w_hit_nxt[3]);
    assign w_score_sum = 17'(r_score) + 17'(w_pop);

    always_ff @(posedge clk22) begin
        if (rst) begin
            r_score <= 16'd0;
        end else begin
            r_score <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
        end
    end

    assign score = r_score;
`endif

endmodule

// File: tb/tb_player_bullet.sv
// Scoreboard bench for player_bullet: directed ticks push expectations, a monitor checks each edge.
module tb_player_bullet;

    logic        clk22 = 1'b0;
    logic        rst, fire;
    logic [9:0]  reimux, reimuy;
    logic [9:0]  enmx1, enmx2, enmx3, enmx4, enmy1, enmy2, enmy3, enmy4;
    logic        enm1, enm2, enm3, enm4;
    logic [3:0]  bullet;
    logic [39:0] bulletx, bullety;
    logic [3:0]  enm_hit;
`ifdef SCORE_EN
    logic [15:0] score;
`endif

    player_bullet dut (
        .clk22(clk22), .rst(rst), .fire(fire),
        .reimux(reimux), .reimuy(reimuy),
        .enmx1(enmx1), .enmx2(enmx2), .enmx3(enmx3), .enmx4(enmx4),
        .enmy1(enmy1), .enmy2(enmy2), .enmy3(enmy3), .enmy4(enmy4),
        .enm1(enm1), .enm2(enm2), .enm3(enm3), .enm4(enm4),
        .bullet(bullet), .bulletx(bulletx), .bullety(bullety),
        .enm_hit(enm_hit)
`ifdef SCORE_EN
        , .score(score)
`endif
    );

    always #5 clk22 = ~clk22;

    typedef struct {
        logic [3:0] b;
        logic [3:0] h;
        int         slot;
        logic [9:0] x;
        logic [9:0] y;
        int         sc;
        int         scn;
        int         idx;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   scn    = 0;
    int   idx    = 0;

    function automatic exp_t mk(input logic [3:0] b, input logic [3:0] h, input int s,
                                input int x, input int y, input int sc);
        exp_t e;
        e.b = b; e.h = h; e.slot = s; e.x = 10'(x); e.y = 10'(y); e.sc = sc;
        e.scn = 0; e.idx = 0;
        return e;
    endfunction

    // One tick: queue the state expected after the next edge, then step past it.
    task automatic cyc(input exp_t e);
        e.scn = scn;
        e.idx = idx;
        idx++;
        q.push_back(e);
        @(posedge clk22);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(mk(4'b0000, 4'b0000, 0, 0, 0, 0));
        rst = 1'b0;
    endtask

    always @(posedge clk22) begin
        exp_t       e;
        logic       bad;
        logic [9:0] gx, gy;
        #2;
        if (q.size() != 0) begin
            e   = q.pop_front();
            bad = 1'b0;
            n_vec++;
            if (bullet !== e.b) begin
                $display("FAIL s%0d.%0d bullet got %b want %b", e.scn, e.idx, bullet, e.b);
                bad = 1'b1;
            end
            if (enm_hit !== e.h) begin
                $display("FAIL s%0d.%0d enm_hit got %b want %b", e.scn, e.idx, enm_hit, e.h);
                bad = 1'b1;
            end
            if (e.slot >= 0) begin
                gx = bulletx[10*e.slot +: 10];
                gy = bullety[10*e.slot +: 10];
                if (gx !== e.x || gy !== e.y) begin
                    $display("FAIL s%0d.%0d slot%0d xy got (%0d,%0d) want (%0d,%0d)",
                             e.scn, e.idx, e.slot, gx, gy, e.x, e.y);
                    bad = 1'b1;
                end
            end
`ifdef SCORE_EN
            if (score !== 16'(e.sc)) begin
                $display("FAIL s%0d.%0d score got %0d want %0d", e.scn, e.idx, score, e.sc);
                bad = 1'b1;
            end
`endif
            if (bad) n_miss++;
        end
    end

    initial begin
        rst = 1'b1; fire = 1'b0; reimux = 10'd0; reimuy = 10'd0;
        enmx1 = 10'd0; enmx2 = 10'd0; enmx3 = 10'd0; enmx4 = 10'd0;
        enmy1 = 10'd0; enmy2 = 10'd0; enmy3 = 10'd0; enmy4 = 10'd0;
        enm1 = 1'b0; enm2 = 1'b0; enm3 = 1'b0; enm4 = 1'b0;

        // Reset state.
        scn = 0;
        cyc(mk(4'b0000, 4'b0000, 0, 0, 0, 0));
        cyc(mk(4'b0000, 4'b0000, 3, 0, 0, 0));

        // Single shot from (200,400).
        scn = 1; idx = 0;
        rst = 1'b0; reimux = 10'd200; reimuy = 10'd400; fire = 1'b1;
        cyc(mk(4'b0001, 4'b0000, 0, 200, 388, 0));
        fire = 1'b0;
        for (int k = 1; k <= 3; k++) cyc(mk(4'b0001, 4'b0000, 0, 200, 388 - 8*k, 0));
        do_reset();

        // Hit on live enemy1 at (200,100): hit evaluated the tick after y=108.
        scn = 2; idx = 0;
        enmx1 = 10'd200; enmy1 = 10'd100; enm1 = 1'b1; fire = 1'b1;
        cyc(mk(4'b0001, 4'b0000, 0, 200, 388, 0));
        fire = 1'b0;
        for (int k = 1; k <= 35; k++) cyc(mk(4'b0001, 4'b0000, 0, 200, 388 - 8*k, 0));
        cyc(mk(4'b0000, 4'b0001, -1, 0, 0, 1));
        cyc(mk(4'b0000, 4'b0000, -1, 0, 0, 1));
        do_reset();

        // Dead enemy: bullet passes through and exits after y=12, holding coordinates.
        scn = 3; idx = 0;
        enm1 = 1'b0; fire = 1'b1;
        cyc(mk(4'b0001, 4'b0000, 0, 200, 388, 0));
        fire = 1'b0;
        for (int k = 1; k <= 47; k++) cyc(mk(4'b0001, 4'b0000, 0, 200, 388 - 8*k, 0));
        cyc(mk(4'b0000, 4'b0000, 0, 200, 12, 0));
        cyc(mk(4'b0000, 4'b0000, 0, 200, 12, 0));
        do_reset();

        // Held fire: spawns every 6 ticks, pool full at 24, resumes the tick after slot0 frees.
        scn = 4; idx = 0;
        fire = 1'b1;
        for (int t = 0; t <= 49; t++) begin
            logic [3:0] b;
            int         y;
            b = (t < 6) ? 4'b0001 : (t < 12) ? 4'b0011 : (t < 18) ? 4'b0111 :
                (t < 48) ? 4'b1111 : (t == 48) ? 4'b1110 : 4'b1111;
            y = (t <= 47) ? 388 - 8*t : (t == 48) ? 12 : 388;
            cyc(mk(b, 4'b0000, 0, 200, y, 0));
        end
        fire = 1'b0;
        do_reset();

        // Two bullets in enemy3's box; the one also in enemy2's box credits enemy2.
        scn = 5; idx = 0;
        enmx2 = 10'd90;  enmy2 = 10'd200; enm2 = 1'b1;
        enmx3 = 10'd105; enmy3 = 10'd200; enm3 = 1'b1;
        reimux = 10'd100; reimuy = 10'd400; fire = 1'b1;
        cyc(mk(4'b0001, 4'b0000, 0, 100, 388, 0));
        fire = 1'b0;
        for (int t = 1; t <= 5; t++) cyc(mk(4'b0001, 4'b0000, 0, 100, 388 - 8*t, 0));
        reimux = 10'd110; reimuy = 10'd352; fire = 1'b1;
        cyc(mk(4'b0011, 4'b0000, 1, 110, 340, 0));
        fire = 1'b0;
        for (int t = 7; t <= 23; t++) cyc(mk(4'b0011, 4'b0000, 0, 100, 340 - 8*(t-6), 0));
        cyc(mk(4'b0000, 4'b0110, -1, 0, 0, 2));
        cyc(mk(4'b0000, 4'b0000, -1, 0, 0, 2));
        enm2 = 1'b0; enm3 = 1'b0;
        do_reset();

        // Hit box crossing x=1023 must not wrap.
        scn = 6; idx = 0;
        reimux = 10'd1015; reimuy = 10'd400;
        enmx4 = 10'd1020; enmy4 = 10'd380; enm4 = 1'b1; fire = 1'b1;
        cyc(mk(4'b0001, 4'b0000, 0, 1015, 388, 0));
        fire = 1'b0;
        cyc(mk(4'b0000, 4'b1000, -1, 0, 0, 1));
        cyc(mk(4'b0000, 4'b0000, -1, 0, 0, 1));
        enm4 = 1'b0;
        do_reset();

        // reimuy below 12 clamps spawn y to 0, exits next tick.
        scn = 7; idx = 0;
        reimux = 10'd50; reimuy = 10'd5; fire = 1'b1;
        cyc(mk(4'b0001, 4'b0000, 0, 50, 0, 0));
        fire = 1'b0;
        cyc(mk(4'b0000, 4'b0000, 0, 50, 0, 0));
        do_reset();

        // Reset with three slots flying, then immediate respawn into slot0.
        scn = 8; idx = 0;
        reimux = 10'd300; reimuy = 10'd400; fire = 1'b1;
        for (int t = 0; t <= 12; t++) begin
            logic [3:0] b;
            b = (t < 6) ? 4'b0001 : (t < 12) ? 4'b0011 : 4'b0111;
            cyc(mk(b, 4'b0000, 0, 300, 388 - 8*t, 0));
        end
        rst = 1'b1;
        cyc(mk(4'b0000, 4'b0000, 2, 0, 0, 0));
        rst = 1'b0;
        cyc(mk(4'b0001, 4'b0000, 0, 300, 388, 0));
        fire = 1'b0;
        cyc(mk(4'b0001, 4'b0000, 0, 300, 380, 0));

        repeat (3) @(posedge clk22);
        #3;
        if (q.size() != 0) begin
            $display("FAIL drain queue left %0d want 0", q.size());
            n_miss++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
